dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the MEM-stage load/store interface.
- Accepts one load or store from the MEM stage, holds the pipeline with `busy` for a fixed latency, then performs the access.
- For loads, returns the data with a one-cycle `read_valid` pulse.
- Replaces the single-cycle data memory so slower storage can sit behind the pipeline.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit doublewords; power of two, at least 2.
- LATENCY, 2, cycles `busy` stays high per accepted request; at least 1.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- MemRead  input  1  load request level from MEM stage
- MemWrite  input  1  store request level from MEM stage
- address  input  64  byte address (`alu_result` of MEM stage)
- write_data  input  64  store data
- read_data  output  64  load data, valid only while `read_valid`=1
- read_valid  output  1  one-cycle pulse, load data returned
- busy  output  1  stall request to pipeline
- misaligned  output  1  one-cycle pulse, request rejected for misalignment

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - `read_data`=0, `read_valid`=0, `busy`=0, `misaligned`=0, latency counter=0.
  - Memory array is not cleared.
  - Reset mid-request aborts it; no write is performed unless the completion edge occurred before reset assertion.
- All outputs are registered.
- States and transitions:
  - IDLE:
    - At an edge with MemWrite=1 or MemRead=1, sample `address`/`write_data`/op.
    - If MemWrite=1 and MemRead=1, store wins and the read is ignored.
    - If `address[2:0]`!=0: no access; `misaligned`=1 for the next cycle; `read_data`=0; state goes to RESP.
    - Otherwise: state goes to ACCESS, counter=LATENCY-1, `busy`=1 from the next cycle.
  - ACCESS:
    - `busy`=1.
    - Each edge with counter!=0 decrements the counter.
    - At the edge with counter==0:
      - Store: write `mem[idx]`=`write_data`.
      - Load: `read_data`=`mem[idx]` and `read_valid`=1.
      - `busy`=0; state goes to RESP.
  - RESP:
    - Exactly one cycle; `busy`=0; `read_valid`/`misaligned` pulse visible.
    - No new request is accepted, because the pipeline is still presenting the same request.
    - Next state is IDLE; pulses clear.
- Index: `idx` = `address[3+log2(DEPTH_WORDS)-1:3]`; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*8.
- Timing: `busy` is high for exactly LATENCY cycles per aligned request.
- Throughput: one request per LATENCY+2 cycles.
- Misaligned request: `busy` never asserts.
- Inputs are sampled only in IDLE; changes while in ACCESS/RESP are ignored.
- Store: `read_valid` stays 0; `read_data` holds its previous value.
- MemRead=MemWrite=0 in IDLE: stay in IDLE, no outputs change.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined: adds outputs `perf_reads[31:0]`, `perf_writes[31:0]`, `perf_stalls[31:0]`.
  - `perf_reads` counts completed loads; `perf_writes` counts completed stores; `perf_stalls` counts cycles with `busy`=1.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
  - Misaligned requests are not counted.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- LATENCY=2; store 64'hDEADBEEF_CAFEF00D to 0x40, then load 0x40:
  - `busy` is high exactly 2 cycles per request.
  - `read_valid` pulses once with `read_data`=64'hDEADBEEF_CAFEF00D.
  - Each request occupies 4 cycles from accept edge to IDLE.
- Load from 0x43 -> `misaligned`=1 for one cycle, `busy` never high, `read_valid`=0, memory unchanged.
- MemRead=MemWrite=1, address 0x08, data 64'h1234 -> store performed, no `read_valid`; a later load of 0x08 returns 64'h1234.
- DEPTH_WORDS=256; store 64'hAA to 0x800 -> a load of 0x000 returns 64'hAA (wrap-around).
- Assert reset_n=0 during ACCESS of a store of 64'h55 to 0x10 (after writing 64'h11 there earlier) -> all outputs 0 immediately; a load of 0x10 after reset returns 64'h11.
- With DMEM_PERF_CNT_EN, LATENCY=3, 2 loads + 1 store + 1 misaligned -> `perf_reads`=2, `perf_writes`=1, `perf_stalls`=9.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one MEM-stage load/store, stalls for LATENCY cycles, then accesses storage.
// Optional performance counters are enabled with `define DMEM_PERF_CNT_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        read_valid,
  output logic        busy,
  output logic        misaligned
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_reads,
  output logic [31:0] perf_writes,
  output logic [31:0] perf_stalls
`endif
);

  localparam int DATA_W = 64;
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                op_wr, op_wr_d;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic                busy_d, rv_d, mis_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                mem_we, accept, req;

  // Upper address bits only alias the array, so they are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^address[63:IDX_W+3];

  assign req = MemRead | MemWrite;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_wr_d = op_wr;
    busy_d  = busy;
    rv_d    = 1'b0;
    mis_d   = 1'b0;
    rdata_d = read_data;
    mem_we  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          op_wr_d = MemWrite;
          if (address[2:0] != 3'b000) begin
            state_d = RESP;
            mis_d   = 1'b1;
            rdata_d = '0;
            busy_d  = 1'b0;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(LATENCY - 1);
            busy_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = RESP;
          if (op_wr) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
            rv_d    = 1'b1;
          end
        end
      end
      RESP: begin
        // The pipeline still presents the finished request here, so nothing is accepted.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      busy       <= 1'b0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
      read_data  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      op_wr      <= op_wr_d;
      busy       <= busy_d;
      read_valid <= rv_d;
      misaligned <= mis_d;
      read_data  <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      idx_q   <= address[IDX_W+2:3];
      wdata_q <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

`ifdef DMEM_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic rd_done, wr_done;
  assign rd_done = (state == ACCESS) && (cnt == '0) && !op_wr;
  assign wr_done = (state == ACCESS) && (cnt == '0) &&  op_wr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_done) perf_reads  <= sat_inc(perf_reads);
      if (wr_done) perf_writes <= sat_inc(perf_writes);
      if (busy)    perf_stalls <= sat_inc(perf_stalls);
    end
  end
`endif

endmodule
